multicycle_controller: RTL
==========================

# multicycle_controller

Finite-state controller for the multicycle RV32I core. It replaces the single-cycle decoder pair with a registered state machine that sequences fetch, decode, execute, memory and writeback over several cycles against a shared instruction/data memory. It generalises the ALU control encoding to a parametrised width, covering the full RV32I integer op set, and resolves all six branch conditions. It adds a memory-ready stall handshake and optional illegal-opcode trapping. It sits between the instruction register and the multicycle datapath.

## Interface
- ALUCTRL_W, 4, width of ALUControl; must be ≥4; upper bits beyond bit 3 are driven 0.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state FETCH.
- op  in  7  instruction opcode from the IR.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- Zero, Lt, Ltu  in  1 each  ALU flags: result zero, signed less-than, unsigned less-than.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write strobes.
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1.
- ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
- ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALUResult.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U; combinational from op in every state.
- ALUControl  out  ALUCTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 pass-B.
- Illegal  out  1  high in state ERROR.

## Operation
- Moore-style outputs decoded from the state register, plus funct3/funct7b5/flags/MemReady where noted. Unlisted strobes are 0; unlisted selects are 00; ALUControl defaults to add.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite=PCWrite=MemReady. Stays while !MemReady, otherwise goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target into ALUOut). Next state by op:
  - 0000011/0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - other → ERROR, or FETCH without the macro.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1. Holds until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. Holds until MemReady, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00.
  - funct3 000 → add, or sub if funct7b5.
  - 001 sll, 010 slt, 011 sltu, 100 xor.
  - 101 → srl, or sra if funct7b5.
  - 110 or, 111 and.
  - Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01. Same map as EXECR, except funct3 000 is always add; funct7b5 is used only for 101. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite=taken, then FETCH. Taken conditions:
  - 000 Zero, 001 !Zero
  - 100 Lt, 101 !Lt
  - 110 Ltu, 111 !Ltu
  - 010/011 → never taken.
- JAL: ResultSrc=00, PCWrite, ALUSrcA=01, ALUSrcB=10, add (link value), then ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, add, then JALRJ. JALRJ behaves as JAL; the datapath clears target bit 0.
- LUI: ALUSrcB=01, pass-B, then ALUWB. AUIPC: ALUSrcA=01, ALUSrcB=01, add, then ALUWB.
- ERROR: all strobes 0, Illegal=1. Exits only via reset.

## Timing
- reset asserted: state FETCH immediately; all write strobes forced 0 while reset is high. Selects show FETCH values; Illegal=0.
- First fetch strobe is on the first rising edge with reset low and MemReady=1.
- Zero-wait latency in cycles:
  - R/I/LUI/AUIPC 4, load 5, store 4.
  - Branch 3, JAL 4, JALR 5.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Strobes stay 0, except MemWrite, which stays high through MEMWRITE.
- Reset mid-instruction: abandons the instruction; no write strobe is asserted after reset rises.
- Branch flags and MemReady are sampled combinationally in the same cycle as their strobe.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: unknown opcodes in DECODE go to ERROR; Illegal asserts and the core halts until reset.
- CTRL_ILLEGAL_TRAP_EN undefined: unknown opcodes return to FETCH as a 2-cycle NOP. ERROR is not built and Illegal is tied 0.

## Test plan
- Reset mid-MEMWRITE with MemReady=0 → MemWrite drops asynchronously, state FETCH, PCWrite=0 while reset high.
- add then sub (funct7b5=1), MemReady=1 → RegWrite in cycle 4; ALUControl 0 then 1 in EXECR; the sub finishes by cycle 8.
- lw with MemReady low for 2 cycles in MEMREAD → RegWrite with ResultSrc=01 in cycle 7.
- bltu, Ltu=1 → PCWrite=1 in cycle 3; bgeu, Ltu=1 → PCWrite=0; funct3=010 → PCWrite=0.
- jalr → PCWrite in cycle 4 (JALRJ), RegWrite in cycle 5 with ResultSrc=00.
- op=0000000 with macro → Illegal=1 from cycle 3 and stays, no strobes. Without macro → IRWrite again in cycle 3.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RV32I control FSM with a memory-ready stall handshake.
// Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in ERROR (otherwise they retire as a NOP).
module multicycle_controller #(
    parameter int unsigned ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    input  logic                 Lt,
    input  logic                 Ltu,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [2:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JALRJ, LUI, AUIPC
`ifdef CTRL_ILLEGAL_TRAP_EN
        , ERROR
`endif
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB  = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
        ALU_XOR  = 4'd4, ALU_SLT  = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
        ALU_SRL  = 4'd8, ALU_SRA  = 4'd9, ALU_PASSB = 4'd10
    } alu_t;

    state_t state, state_next;
    alu_t   alu;
    logic   pcw, irw, regw, memw;

    function automatic alu_t exec_alu(input logic [2:0] f3, input logic alt_sub, input logic alt_sra);
        case (f3)
            3'b000:  return alt_sub ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt_sra ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
        case (f3)
            3'b000:  return z;
            3'b001:  return ~z;
            3'b100:  return lt;
            3'b101:  return ~lt;
            3'b110:  return ltu;
            3'b111:  return ~ltu;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pcw        = 1'b0;
        irw        = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        alu        = ALU_ADD;
        Illegal    = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw       = MemReady;
                pcw       = MemReady;
                if (MemReady) state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECR;
                    OP_ITYPE:          state_next = EXECI;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    OP_JALR:           state_next = JALR;
                    OP_LUI:            state_next = LUI;
                    OP_AUIPC:          state_next = AUIPC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:           state_next = ERROR;
`else
                    default:           state_next = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                regw       = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
                if (MemReady) state_next = FETCH;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                alu        = exec_alu(funct3, funct7b5, funct7b5);
                state_next = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu        = exec_alu(funct3, 1'b0, funct7b5);
                state_next = ALUWB;
            end
            ALUWB: begin
                regw       = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                alu        = ALU_SUB;
                pcw        = branch_taken(funct3, Zero, Lt, Ltu);
                state_next = FETCH;
            end
            // PC takes the target held in ALUOut while the ALU forms OldPC+4 for the link
            JAL, JALRJ: begin
                pcw        = 1'b1;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                state_next = ALUWB;
            end
            JALR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = JALRJ;
            end
            LUI: begin
                ALUSrcB    = 2'b01;
                alu        = ALU_PASSB;
                state_next = ALUWB;
            end
            AUIPC: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                state_next = ALUWB;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ERROR: Illegal = 1'b1;
`endif
            default: state_next = FETCH;
        endcase
    end

    // Reset forces FETCH asynchronously, so strobes are also masked to keep them low while it is held
    assign PCWrite  = pcw  & ~reset;
    assign IRWrite  = irw  & ~reset;
    assign RegWrite = regw & ~reset;
    assign MemWrite = memw & ~reset;

    always_comb begin
        ALUControl      = '0;
        ALUControl[3:0] = alu;
    end

    always_comb begin
        case (op)
            OP_STORE:          ImmSrc = 3'b001;
            OP_BRANCH:         ImmSrc = 3'b010;
            OP_JAL:            ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:  ImmSrc = 3'b100;
            default:           ImmSrc = 3'b000;
        endcase
    end

endmodule
